// File: rtl/issue_queue_aged_pkg.sv
// Shared definitions for the aged issue queue.
//   `PR_ADDR_W     physical register tag width (overridable from the build)
//   payload_lsb    bit offset of a lane payload in the packed din bus
//   tag_lsb        bit offset of a lane/source tag in the packed din_src_tag bus
//   rdy_lsb        bit offset of a lane's rdy bits in the packed din_src_rdy bus
//   min_u/popcount small arithmetic helpers used for the free/occupancy counts
`ifndef PR_ADDR_W
`define PR_ADDR_W 7
`endif

package issue_queue_aged_pkg;

  function automatic int unsigned payload_lsb(input int unsigned lane, input int unsigned data_w);
    return lane * data_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned lane, input int unsigned src,
                                          input int unsigned src_ct, input int unsigned tag_w);
    return (lane * src_ct + src) * tag_w;
  endfunction

  function automatic int unsigned rdy_lsb(input int unsigned lane, input int unsigned src_ct);
    return lane * src_ct;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/issue_queue_slot.sv
// One issue queue slot: valid bit, opaque payload, per-source tags and rdy bits, and
// the wakeup tag compare.
//   clk_i, rst_ni     clock, synchronous active-low reset
//   flush_i           drop the entry (wins over load/clear)
//   load_i, load_*_i  write a newly dispatched entry
//   clear_i           entry issued this cycle
//   wake_tag_i/valid  wakeup broadcast lanes
//   valid_o, data_o   slot state
//   ready_o           valid and all sources ready
// ISSUE_QUEUE_SAME_CYCLE_WAKE_EN: ready_o also counts this cycle's wake matches.
module issue_queue_slot
  import issue_queue_aged_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 47,
  parameter int unsigned SRC_CT     = 2,
  parameter int unsigned WAKE_CT    = 6,
  parameter int unsigned TAG_W      = `PR_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      load_i,
  input  logic [DATA_WIDTH-1:0]     load_data_i,
  input  logic [SRC_CT*TAG_W-1:0]   load_tag_i,
  input  logic [SRC_CT-1:0]         load_rdy_i,
  input  logic                      clear_i,
  input  logic [WAKE_CT*TAG_W-1:0]  wake_tag_i,
  input  logic [WAKE_CT-1:0]        wake_valid_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      ready_o
);

  logic                         valid_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [SRC_CT-1:0][TAG_W-1:0] tag_q;
  logic [SRC_CT-1:0]            rdy_q;
  logic [SRC_CT-1:0]            hit_res;   // wake matches against resident tags
  logic [SRC_CT-1:0]            hit_load;  // wake matches against tags being loaded

  always_comb begin
    hit_res  = '0;
    hit_load = '0;
    for (int s = 0; s < SRC_CT; s++) begin
      for (int w = 0; w < WAKE_CT; w++) begin
        if (wake_valid_i[w]) begin
          if (wake_tag_i[w*TAG_W +: TAG_W] == tag_q[s]) hit_res[s] = 1'b1;
          if (wake_tag_i[w*TAG_W +: TAG_W] == load_tag_i[tag_lsb(0, s, SRC_CT, TAG_W) +: TAG_W])
            hit_load[s] = 1'b1;
        end
      end
    end
  end

  // Payload and tags carry no reset: they are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rdy_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      tag_q   <= load_tag_i;
      rdy_q   <= load_rdy_i | hit_load;
    end else begin
      if (clear_i) valid_q <= 1'b0;
      rdy_q <= rdy_q | hit_res;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
`ifdef ISSUE_QUEUE_SAME_CYCLE_WAKE_EN
  assign ready_o = valid_q & (&(rdy_q | hit_res));
`else
  assign ready_o = valid_q & (&rdy_q);
`endif

endmodule

// File: rtl/issue_queue_aged.sv
// Out-of-order issue queue with age-matrix oldest-first select.
//   clk, rst (sync, active low)
//   din/din_src_tag/din_src_rdy/din_valid_ct  up to PUSH_WIDTH dispatched entries, lane 0 oldest
//   din_ready_ct                              lanes acceptable this cycle (registered state only)
//   dout/dout_valid/dout_ready                ISSUE_WIDTH packed issue ports, port 0 oldest
//   wake_tag/wake_valid                       physical register wakeup broadcasts
//   flush                                     drop every entry and this cycle's inserts
//   occupancy                                 registered valid entry count
// ISSUE_QUEUE_SAME_CYCLE_WAKE_EN (optional, in issue_queue_slot): wake-to-issue in one cycle.
module issue_queue_aged
  import issue_queue_aged_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 47,
  parameter int unsigned PUSH_WIDTH  = 4,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned ELEMENTS    = 8,
  parameter int unsigned SRC_CT      = 2,
  parameter int unsigned WAKE_CT     = 6,
  parameter int unsigned TAG_W       = `PR_ADDR_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PUSH_WIDTH*DATA_WIDTH-1:0]    din,
  input  logic [PUSH_WIDTH*SRC_CT*TAG_W-1:0]  din_src_tag,
  input  logic [PUSH_WIDTH*SRC_CT-1:0]        din_src_rdy,
  input  logic [$clog2(PUSH_WIDTH):0]         din_valid_ct,
  output logic [$clog2(PUSH_WIDTH):0]         din_ready_ct,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]   dout,
  output logic [ISSUE_WIDTH-1:0]              dout_valid,
  input  logic [ISSUE_WIDTH-1:0]              dout_ready,
  input  logic [WAKE_CT*TAG_W-1:0]            wake_tag,
  input  logic [WAKE_CT-1:0]                  wake_valid,
  input  logic                                flush,
  output logic [$clog2(ELEMENTS):0]           occupancy
);

  localparam int unsigned CtW  = $clog2(PUSH_WIDTH) + 1;
  localparam int unsigned OccW = $clog2(ELEMENTS) + 1;

  logic [ELEMENTS-1:0]                 slot_valid;
  logic [ELEMENTS-1:0]                 slot_ready;
  logic [ELEMENTS-1:0][DATA_WIDTH-1:0] slot_data;
  logic [ELEMENTS-1:0]                 load;
  logic [ELEMENTS-1:0]                 clear;
  int unsigned                         lane_of [ELEMENTS];
  int unsigned                         accepted;
  int unsigned                         alloc_ct;
  int unsigned                         rank;
  // older_q[i][j] = 1 means slot j holds an entry older than slot i.
  logic [ELEMENTS-1:0][ELEMENTS-1:0]   older_q, older_d;
  logic [OccW-1:0]                     occupancy_q, occupancy_d;

  assign din_ready_ct = CtW'(min_u(ELEMENTS - popcount(64'(slot_valid)), PUSH_WIDTH));
  assign accepted     = min_u(32'(din_valid_ct), 32'(din_ready_ct));

  // Lane k lands in the k-th lowest-index free slot.
  always_comb begin
    load     = '0;
    alloc_ct = 0;
    for (int i = 0; i < ELEMENTS; i++) begin
      lane_of[i] = 0;
      if (!slot_valid[i] && alloc_ct < accepted) begin
        load[i]    = 1'b1;
        lane_of[i] = alloc_ct;
        alloc_ct   = alloc_ct + 1;
      end
    end
  end

  for (genvar i = 0; i < ELEMENTS; i++) begin : g_slot
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [SRC_CT*TAG_W-1:0] ld_tag;
    logic [SRC_CT-1:0]       ld_rdy;

    assign ld_data = din[payload_lsb(lane_of[i], DATA_WIDTH) +: DATA_WIDTH];
    assign ld_tag  = din_src_tag[tag_lsb(lane_of[i], 0, SRC_CT, TAG_W) +: SRC_CT*TAG_W];
    assign ld_rdy  = din_src_rdy[rdy_lsb(lane_of[i], SRC_CT) +: SRC_CT];

    issue_queue_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .SRC_CT     (SRC_CT),
      .WAKE_CT    (WAKE_CT),
      .TAG_W      (TAG_W)
    ) u_slot (
      .clk_i        (clk),
      .rst_ni       (rst),
      .flush_i      (flush),
      .load_i       (load[i]),
      .load_data_i  (ld_data),
      .load_tag_i   (ld_tag),
      .load_rdy_i   (ld_rdy),
      .clear_i      (clear[i]),
      .wake_tag_i   (wake_tag),
      .wake_valid_i (wake_valid),
      .valid_o      (slot_valid[i]),
      .data_o       (slot_data[i]),
      .ready_o      (slot_ready[i])
    );
  end

  // A new row sees every resident entry plus lower-numbered lanes as older. Its column is
  // cleared in all other rows so stale bits from the slot's previous occupant disappear.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < ELEMENTS; i++) begin
      for (int j = 0; j < ELEMENTS; j++) begin
        if (load[i]) begin
          older_d[i][j] = slot_valid[j] | (load[j] & (lane_of[j] < lane_of[i]));
        end else if (load[j]) begin
          older_d[i][j] = 1'b0;
        end
      end
    end
  end

  // The number of older ready entries is the issue port a ready entry lands on.
  always_comb begin
    dout       = '0;
    dout_valid = '0;
    clear      = '0;
    rank       = 0;
    for (int i = 0; i < ELEMENTS; i++) begin
      rank = popcount(64'(slot_ready & older_q[i]));
      if (slot_ready[i]) begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
          if (rank == p) begin
            dout_valid[p]                    = 1'b1;
            dout[p*DATA_WIDTH +: DATA_WIDTH] = slot_data[i];
            clear[i]                         = dout_ready[p];
          end
        end
      end
    end
  end

  always_comb begin
    occupancy_d = '0;
    if (!flush) begin
      occupancy_d = OccW'(popcount(64'(slot_valid)) + popcount(64'(load))
                          - popcount(64'(clear)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      older_q     <= '0;
      occupancy_q <= '0;
    end else if (flush) begin
      older_q     <= '0;
      occupancy_q <= '0;
    end else begin
      older_q     <= older_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_issue_queue_aged.sv
module tb_issue_queue_aged;

`ifdef ISSUE_QUEUE_SAME_CYCLE_WAKE_EN
  localparam bit SameCycle = 1'b1;
`else
  localparam bit SameCycle = 1'b0;
`endif

  localparam int DW = 47;
  localparam int TW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [4*DW-1:0] din;
  logic [8*TW-1:0] din_src_tag;
  logic [7:0]      din_src_rdy;
  logic [2:0]      din_valid_ct;
  logic [2:0]      din_ready_ct;
  logic [2*DW-1:0] dout;
  logic [1:0]      dout_valid;
  logic [1:0]      dout_ready;
  logic [6*TW-1:0] wake_tag;
  logic [5:0]      wake_valid;
  logic            flush;
  logic [3:0]      occupancy;

  int checks = 0;
  int errors = 0;

  issue_queue_aged #(
    .DATA_WIDTH  (DW),
    .PUSH_WIDTH  (4),
    .ISSUE_WIDTH (2),
    .ELEMENTS    (8),
    .SRC_CT      (2),
    .WAKE_CT     (6),
    .TAG_W       (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_src_tag  (din_src_tag),
    .din_src_rdy  (din_src_rdy),
    .din_valid_ct (din_valid_ct),
    .din_ready_ct (din_ready_ct),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .wake_tag     (wake_tag),
    .wake_valid   (wake_valid),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  typedef struct {
    logic       rst_n;
    logic       flush;
    logic [2:0] vct;
    int         id;    // lane k payload = id + k
    logic [3:0] nr;    // lane k source 0 not ready, waits on tag
    logic [6:0] tag;
    logic       wv;
    logic [6:0] wt;
    logic [1:0] dr;
    int         rct;
    logic [1:0] dv;
    int         d0;
    int         d1;
    int         occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic fl, input int vct, input int id,
                              input logic [3:0] nr, input int tag, input logic wv, input int wt,
                              input logic [1:0] dr, input int rct, input logic [1:0] dv,
                              input int d0, input int d1, input int occ);
    vec_t v;
    v.rst_n = rst_n; v.flush = fl; v.vct = 3'(vct); v.id = id; v.nr = nr; v.tag = 7'(tag);
    v.wv = wv; v.wt = 7'(wt); v.dr = dr; v.rct = rct; v.dv = dv; v.d0 = d0; v.d1 = d1;
    v.occ = occ;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b1; flush = 1'b0; din_valid_ct = '0; din = '0; din_src_tag = '0;
    din_src_rdy = '1; wake_tag = '0; wake_valid = '0; dout_ready = '0;
  endtask

  task automatic check_outputs(input int idx, input int rct, input logic [1:0] dv,
                               input int d0, input int d1, input int occ);
    check("din_ready_ct", idx, longint'(din_ready_ct), longint'(rct));
    check("dout_valid", idx, longint'(dout_valid), longint'(dv));
    check("occupancy", idx, longint'(occupancy), longint'(occ));
    if (dv[0]) check("dout0", idx, longint'(dout[DW-1:0]), longint'(d0));
    if (dv[1]) check("dout1", idx, longint'(dout[2*DW-1:DW]), longint'(d1));
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    idle_inputs();
    rst = t.rst_n; flush = t.flush; din_valid_ct = t.vct; dout_ready = t.dr;
    for (int k = 0; k < 4; k++) begin
      din[k*DW +: DW]               = DW'(t.id + k);
      din_src_tag[(2*k)*TW +: TW]   = t.tag;
      din_src_tag[(2*k+1)*TW +: TW] = '0;
      din_src_rdy[2*k]              = ~t.nr[k];
      din_src_rdy[2*k+1]            = 1'b1;
    end
    wake_tag[TW-1:0] = t.wt;
    wake_valid[0]    = t.wv;
    #1;
    check_outputs(idx, t.rct, t.dv, t.d0, t.d1, t.occ);
  endtask

  initial begin
    //          rst fl vct id  nr       tag wv wt  dr     rct dv  d0  d1  occ
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3, 10, 4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b11, 10, 11, 3));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b01, 12, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    // A waits on tag 5, B ready: B overtakes A
    vecs.push_back(mk(1, 0, 1, 20, 4'b0001, 5, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 21, 4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b01, 21, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 1, 5,  2'b11, 4,
                      SameCycle ? 2'b01 : 2'b00, SameCycle ? 20 : 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4,
                      SameCycle ? 2'b00 : 2'b01, SameCycle ? 0 : 20, 0, SameCycle ? 0 : 1));
    // fill all 8 slots with entries waiting on tag 9
    vecs.push_back(mk(1, 0, 4, 30, 4'b1111, 9, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4, 34, 4'b1111, 9, 0, 0,  2'b11, 4, 2'b00, 0, 0, 4));
    vecs.push_back(mk(1, 0, 4, 40, 4'b0000, 0, 0, 0,  2'b11, 0, 2'b00, 0, 0, 8));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 1, 9,  2'b00, 0,
                      SameCycle ? 2'b11 : 2'b00, SameCycle ? 30 : 0, SameCycle ? 31 : 0, 8));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 0, 2'b11, 30, 31, 8));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b01, 2, 2'b11, 32, 33, 6));
    // flush with 5 resident plus a 2-lane insert
    vecs.push_back(mk(1, 1, 2, 50, 4'b0000, 0, 0, 0,  2'b11, 3, 2'b11, 33, 34, 5));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    // dispatch/wake race on tag 12
    vecs.push_back(mk(1, 0, 1, 60, 4'b0001, 12, 1, 12, 2'b11, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b00, 4, 2'b01, 60, 0, 1));
    // slot reuse: younger entry in a lower-index slot must not jump ahead
    vecs.push_back(mk(1, 0, 2, 61, 4'b0000, 0, 0, 0,  2'b00, 4, 2'b01, 60, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b01, 4, 2'b11, 60, 61, 3));
    vecs.push_back(mk(1, 0, 1, 63, 4'b0000, 0, 0, 0,  2'b00, 4, 2'b11, 61, 62, 2));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b11, 61, 62, 3));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b01, 63, 0, 1));
    // stalled port gives way when an older entry wakes
    vecs.push_back(mk(1, 0, 1, 70, 4'b0001, 20, 0, 0, 2'b00, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 71, 4'b0000, 0, 0, 0,  2'b00, 4, 2'b00, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 1, 20, 2'b00, 4,
                      SameCycle ? 2'b11 : 2'b01, SameCycle ? 70 : 71, SameCycle ? 71 : 0, 2));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b00, 4, 2'b11, 70, 71, 2));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b11, 70, 71, 2));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));
    // partial acceptance, then reset mid-issue
    vecs.push_back(mk(1, 0, 4, 80, 4'b1111, 30, 0, 0, 2'b11, 4, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3, 84, 4'b1111, 30, 0, 0, 2'b11, 4, 2'b00, 0, 0, 4));
    vecs.push_back(mk(1, 0, 4, 90, 4'b0000, 0, 0, 0,  2'b11, 1, 2'b00, 0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b00, 0, 2'b01, 90, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 0, 2'b01, 90, 0, 8));
    vecs.push_back(mk(1, 0, 0, 0,  4'b0000, 0, 0, 0,  2'b11, 4, 2'b00, 0, 0, 0));

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) apply(vecs[i], i);

    // Both sources outstanding; duplicate wake lanes for tag 3 plus tag 4 on another lane.
    @(negedge clk);
    idle_inputs();
    din_valid_ct = 3'd1;
    din[DW-1:0] = DW'(100);
    din_src_tag[TW-1:0] = 7'd3;
    din_src_tag[2*TW-1:TW] = 7'd4;
    din_src_rdy[1:0] = 2'b00;
    wake_tag[TW-1:0] = 7'd3; wake_tag[2*TW-1:TW] = 7'd3; wake_tag[3*TW-1:2*TW] = 7'd4;
    wake_valid = 6'b000111;
    @(negedge clk);
    idle_inputs();
    #1;
    check_outputs(100, 4, 2'b01, 100, 0, 1);

    // Entry needing two separate wakes: one source alone is not enough.
    @(negedge clk);
    idle_inputs();
    din_valid_ct = 3'd1;
    din[DW-1:0] = DW'(101);
    din_src_tag[TW-1:0] = 7'd6;
    din_src_tag[2*TW-1:TW] = 7'd7;
    din_src_rdy[1:0] = 2'b00;
    @(negedge clk);
    idle_inputs();
    wake_tag[TW-1:0] = 7'd6;
    wake_valid = 6'b000001;
    #1;
    check_outputs(101, 4, 2'b01, 100, 0, 2);
    @(negedge clk);
    idle_inputs();
    wake_tag[5*TW +: TW] = 7'd7;
    wake_valid = 6'b100000;
    #1;
    check_outputs(102, 4, SameCycle ? 2'b11 : 2'b01, 100, 101, 2);
    @(negedge clk);
    idle_inputs();
    #1;
    check_outputs(103, 4, 2'b11, 100, 101, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue_aged.md
Name: issue_queue_aged

Overview:
- Parametrised out-of-order issue queue, the successor to the single-issue issue buffer.
- Accepts up to PUSH_WIDTH renamed instructions per cycle and tracks per-source physical-register readiness through tag wakeup broadcasts.
- Issues up to ISSUE_WIDTH ready instructions per cycle, oldest first, using an age matrix.
- Sits between rename/dispatch and the execution ports; supports a whole-queue flush on branch mispredict.

Parameters:
- DATA_WIDTH, 47, payload bits per instruction (opaque to the queue).
- PUSH_WIDTH, 4, maximum instructions inserted per cycle.
- ISSUE_WIDTH, 2, number of issue ports.
- ELEMENTS, 8, number of queue slots (>= PUSH_WIDTH).
- SRC_CT, 2, source operands per instruction.
- WAKE_CT, 6, wakeup broadcast lanes per cycle.
- TAG_W, `PR_ADDR_W, physical register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- din  in  PUSH_WIDTH*DATA_WIDTH  payloads; lane 0 is the oldest.
- din_src_tag  in  PUSH_WIDTH*SRC_CT*TAG_W  source tags.
- din_src_rdy  in  PUSH_WIDTH*SRC_CT  source already ready at dispatch.
- din_valid_ct  in  $clog2(PUSH_WIDTH)+1  valid lanes, packed from lane 0.
- din_ready_ct  out  $clog2(PUSH_WIDTH)+1  lanes acceptable this cycle.
- dout  out  ISSUE_WIDTH*DATA_WIDTH  issued payloads.
- dout_valid  out  ISSUE_WIDTH  per-port valid.
- dout_ready  in  ISSUE_WIDTH  per-port ready.
- wake_tag  in  WAKE_CT*TAG_W  completing physical registers.
- wake_valid  in  WAKE_CT  per-lane valid.
- flush  in  1  discard all entries.
- occupancy  out  $clog2(ELEMENTS)+1  valid entry count (registered).

Behaviour:
- Slot state: valid, payload, per-source tag and rdy bit, and an age-matrix row where older[i][j]=1 means slot j is older than slot i.
- Reset (rst==0 at a clk edge):
  - All valid bits and the age matrix clear.
  - dout_valid=0, occupancy=0, din_ready_ct=min(ELEMENTS,PUSH_WIDTH) from the following cycle.
  - Reset wins over flush, insert and issue in the same cycle.
- din_ready_ct = min(free slots, PUSH_WIDTH), computed from registered valid bits only.
  - Slots freed by issue in the current cycle are reusable next cycle, never the same cycle.
  - din_ready_ct does not depend on din_valid_ct.
- Insert:
  - accepted = min(din_valid_ct, din_ready_ct).
  - Lane k goes to the k-th lowest-index free slot.
  - The new entry is younger than all existing entries, and lane k is older than lane k+1.
- Wakeup:
  - A source whose tag matches any valid wake lane sets rdy at the clk edge.
  - Applies to resident entries and to entries being inserted that cycle, so a dispatch/wake race loses no wakeup.
  - Duplicate wake tags are harmless.
- Readiness: an entry is ready when valid and all SRC_CT rdy bits are registered 1. A wake in cycle N makes the entry issuable in cycle N+1.
- Select:
  - Port 0 takes the oldest ready entry, port 1 the next oldest, and so on.
  - Valid ports are packed: dout_valid[p] implies dout_valid[p-1].
  - dout and dout_valid are combinational from registered state only; no dout_ready->dout_valid path.
- Issue/dequeue:
  - The entry on port p frees at the edge when dout_valid[p]&dout_ready[p].
  - A stalled port keeps the same entry only if no older entry became ready; the selection is recomputed every cycle.
- Flush:
  - All valid bits clear at the edge and inserts that cycle are dropped.
  - dout_valid still reflects pre-flush state during the flush cycle; consumers must ignore issue in that cycle.
- occupancy = next-state popcount of the valid bits; it never exceeds ELEMENTS.
- Full queue: din_ready_ct=0 and inserts are ignored. Empty queue: dout_valid=0.
- din_valid_ct > din_ready_ct is legal; only din_ready_ct lanes are taken.

Optional Feature:
- ISSUE_QUEUE_SAME_CYCLE_WAKE_EN defined: for resident entries, ready also counts sources matched by the current wake_tag combinationally, so a wake in cycle N allows issue in cycle N. This adds a wake_tag->dout_valid combinational path.
- Undefined: one-cycle wake-to-issue latency as specified above.

Decomposition:
- Shared header/package:
  - `PR_ADDR_W.
  - Slot field offsets (payload, tags, rdy).
  - A min/popcount helper function.
- One sub-module, issue_queue_slot, instanced ELEMENTS times. It holds the valid bit, payload, tags and rdy bits, does the wake tag compare, and outputs ready.
- The age matrix and select logic stay in the top.

Test Plan:
- Reset, then idle -> din_ready_ct=4, dout_valid=00, occupancy=0.
- Insert 3 with all sources ready, dout_ready=11 -> next cycle issues lane0 on port 0 and lane1 on port 1, then lane2 the cycle after; occupancy 3->1->0.
- Insert A (src tag 5 not ready), then B (ready) -> B issues first. After wake_tag=5, A issues exactly one cycle later (same cycle with the macro defined).
- Fill 8 slots -> din_ready_ct=0 and a 4-lane insert is ignored. Issue 2 -> din_ready_ct=2 next cycle, not same cycle.
- Insert with wake_tag equal to the dispatching source tag in the same cycle -> entry ready next cycle; no lost wakeup.
- Flush with 5 entries plus a concurrent insert of 2 -> occupancy=0, dout_valid=00 next cycle. Reset asserted mid-issue -> all outputs at reset values.
